rotor_step_ctrl: RTL and testbench
==================================

ROTOR_STEP_CTRL -- requirements
Module: rotor_step_ctrl

Interface
REQ-001 Parameter: WIDTH, 8, bit width of every position/notch bus.
REQ-002 Parameter: ALPHA, 26, rotor modulus (positions 0..ALPHA-1).
REQ-003 Port: clk  input  1  sole clock, rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous, active-high.
REQ-005 Port: load  input  1  load start positions (honoured only in IDLE).
REQ-006 Port: load_pos_l/m/r  input  WIDTH each  start positions for left/middle/right rotors.
REQ-007 Port: notch_m, notch_r  input  WIDTH each  turnover position of middle/right rotor.
REQ-008 Port: key_valid  input  1  keypress request.
REQ-009 Port: key_ready  output  1  high only in IDLE with load low.
REQ-010 Port: pos_l, pos_m, pos_r  output  WIDTH each  registered rotor positions.
REQ-011 Port: step_valid  output  1  one-cycle pulse, new positions valid.
REQ-012 Port: busy  output  1  high in any state other than IDLE.

Function
REQ-013 FSM states SHALL be IDLE, EVAL, STEP, DONE; encoding free.
REQ-014 IDLE -> EVAL on key_valid && key_ready; otherwise remain IDLE.
REQ-015 EVAL: register step flags from current positions; -> STEP unconditionally.
REQ-016 STEP: update positions from flags; -> DONE unconditionally.
REQ-017 DONE: step_valid=1 for exactly this cycle; -> IDLE unconditionally.
REQ-018 Latency: accept in cycle N, positions change at edge ending N+2, step_valid high in N+3, key_ready high again in N+4.
REQ-019 Right rotor SHALL step on every accepted key.
REQ-020 Middle steps when pos_r == notch_r (value sampled in EVAL, before stepping).
REQ-021 Left steps when middle steps due to REQ-020 and pos_m == notch_m (sampled in EVAL).
REQ-022 Increment SHALL wrap: ALPHA-1 -> 0, else +1; no other arithmetic on positions.
REQ-023 load in IDLE: positions take load_pos_* at next edge; any value >= ALPHA is stored as 0.
REQ-024 load and key_valid in same IDLE cycle: load wins, key not accepted (key_ready low).
REQ-025 load while busy SHALL be ignored, no effect on positions or FSM.
REQ-026 key_valid while busy SHALL be ignored (not queued).
REQ-027 notch_* >= ALPHA SHALL never match; the corresponding rotor never carries.
REQ-028 Positions SHALL remain < ALPHA at all times after reset.

Reset
REQ-029 rst asserted SHALL immediately force FSM to IDLE regardless of clock.
REQ-030 Reset values: pos_l=pos_m=pos_r=0, step_valid=0, busy=0, step flags=0; key_ready=1 once rst deasserts (load low).
REQ-031 rst mid-operation (EVAL/STEP/DONE) SHALL abandon the step; no step_valid pulse follows.

Configuration
REQ-032 Macro DOUBLE_STEP_EN: when defined, middle additionally steps whenever pos_m == notch_m (sampled in EVAL), independent of REQ-020, reproducing double-stepping; left rule becomes pos_m == notch_m alone.
REQ-033 Without DOUBLE_STEP_EN: pure odometer behaviour per REQ-019..021 only.

Verification
REQ-034 Reset, then key with positions 0/0/0, notches 16/4 -> step_valid after 3 cycles, positions 0/0/1.
REQ-035 Load 0/0/25, notch_r=25, key -> positions 0/1/0 (wrap plus carry).
REQ-036 Load 0/3/16, notch_r=16, notch_m=4, two keys -> after 1st 0/4/17; after 2nd: with DOUBLE_STEP_EN 1/5/18, without 0/4/18.
REQ-037 load and key_valid asserted together in IDLE with load_pos 30/2/27 -> positions 0/2/0, no step_valid, key_ready low that cycle.
REQ-038 key accepted, rst asserted during STEP -> positions 0/0/0 immediately, FSM IDLE, no step_valid pulse.
REQ-039 key_valid and load held high through EVAL/STEP/DONE -> single step only, load ignored until IDLE.

Source files
------------

// File: rtl/rotor_step_ctrl_if.sv
// ============================================================================
// Module   : rotor_step_ctrl_if
// Brief    : Load / keypress / position bundle for the rotor stepping controller.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface rotor_step_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             load;
    logic [WIDTH-1:0] load_pos_l;
    logic [WIDTH-1:0] load_pos_m;
    logic [WIDTH-1:0] load_pos_r;
    logic [WIDTH-1:0] notch_m;
    logic [WIDTH-1:0] notch_r;
    logic             key_valid;
    logic             key_ready;
    logic [WIDTH-1:0] pos_l;
    logic [WIDTH-1:0] pos_m;
    logic [WIDTH-1:0] pos_r;
    logic             step_valid;
    logic             busy;

    modport master (
        output load, load_pos_l, load_pos_m, load_pos_r,
        output notch_m, notch_r, key_valid,
        input  key_ready, pos_l, pos_m, pos_r, step_valid, busy
    );

    modport slave (
        input  load, load_pos_l, load_pos_m, load_pos_r,
        input  notch_m, notch_r, key_valid,
        output key_ready, pos_l, pos_m, pos_r, step_valid, busy
    );
endinterface

`default_nettype wire

// File: rtl/rotor_step_ctrl.sv
// ============================================================================
// Module   : rotor_step_ctrl
// Brief    : Three-rotor odometer stepping controller (IDLE/EVAL/STEP/DONE).
//            Define DOUBLE_STEP_EN to reproduce middle-rotor double-stepping.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module rotor_step_ctrl #(
    parameter int WIDTH = 8,
    parameter int ALPHA = 26
) (
    input  logic              clk,
    input  logic              rst,
    rotor_step_ctrl_if.slave  bus
);

    localparam logic [WIDTH-1:0] C_ALPHA = WIDTH'(ALPHA);
    localparam logic [WIDTH-1:0] C_LAST  = WIDTH'(ALPHA - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EVAL = 2'd1,
        S_STEP = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pos_l_q, pos_l_d;
    logic [WIDTH-1:0] pos_m_q, pos_m_d;
    logic [WIDTH-1:0] pos_r_q, pos_r_d;
    logic             step_l_q, step_l_d;
    logic             step_m_q, step_m_d;
    logic             step_r_q, step_r_d;
    logic             step_valid_q, step_valid_d;

    logic             hit_r;
    logic             hit_m;

    function automatic logic [WIDTH-1:0] f_inc(input logic [WIDTH-1:0] p);
        return (p == C_LAST) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [WIDTH-1:0] f_clean(input logic [WIDTH-1:0] p);
        return (p >= C_ALPHA) ? '0 : p;
    endfunction

    // An out-of-range notch can never equal a legal position, but is gated
    // explicitly so the carry is suppressed even if a position were corrupt.
    assign hit_r = (pos_r_q == bus.notch_r) && (bus.notch_r < C_ALPHA);
    assign hit_m = (pos_m_q == bus.notch_m) && (bus.notch_m < C_ALPHA);

    always_comb begin
        state_d      = state_q;
        pos_l_d      = pos_l_q;
        pos_m_d      = pos_m_q;
        pos_r_d      = pos_r_q;
        step_l_d     = step_l_q;
        step_m_d     = step_m_q;
        step_r_d     = step_r_q;
        step_valid_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.load) begin
                    pos_l_d = f_clean(bus.load_pos_l);
                    pos_m_d = f_clean(bus.load_pos_m);
                    pos_r_d = f_clean(bus.load_pos_r);
                end else if (bus.key_valid) begin
                    state_d = S_EVAL;
                end
            end
            S_EVAL: begin
                step_r_d = 1'b1;
`ifdef DOUBLE_STEP_EN
                step_m_d = hit_r || hit_m;
                step_l_d = hit_m;
`else
                step_m_d = hit_r;
                step_l_d = hit_r && hit_m;
`endif
                state_d  = S_STEP;
            end
            S_STEP: begin
                if (step_r_q) pos_r_d = f_inc(pos_r_q);
                if (step_m_q) pos_m_d = f_inc(pos_m_q);
                if (step_l_q) pos_l_d = f_inc(pos_l_q);
                step_valid_d = 1'b1;
                state_d      = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            pos_l_q      <= '0;
            pos_m_q      <= '0;
            pos_r_q      <= '0;
            step_l_q     <= 1'b0;
            step_m_q     <= 1'b0;
            step_r_q     <= 1'b0;
            step_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pos_l_q      <= pos_l_d;
            pos_m_q      <= pos_m_d;
            pos_r_q      <= pos_r_d;
            step_l_q     <= step_l_d;
            step_m_q     <= step_m_d;
            step_r_q     <= step_r_d;
            step_valid_q <= step_valid_d;
        end
    end

    // A pending load takes priority, so the key is refused in that cycle.
    assign bus.key_ready  = (state_q == S_IDLE) && !bus.load;
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.step_valid = step_valid_q;
    assign bus.pos_l      = pos_l_q;
    assign bus.pos_m      = pos_m_q;
    assign bus.pos_r      = pos_r_q;

endmodule

`default_nettype wire

// File: tb/tb_rotor_step_ctrl.sv
// ============================================================================
// Module   : tb_rotor_step_ctrl
// Brief    : Self-checking bench for rotor_step_ctrl with a modular-arithmetic
//            reference model, directed scenarios and randomized traffic.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rotor_step_ctrl;

    localparam int WIDTH = 8;
    localparam int ALPHA = 26;

    logic clk;
    logic rst;

    rotor_step_ctrl_if #(.WIDTH(WIDTH)) bus ();

    rotor_step_ctrl #(.WIDTH(WIDTH), .ALPHA(ALPHA)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests;
    int n_fail;
    int sv_count;
    int exp_pulses;

    // reference model state
    int ml, mm, mr;
    int nm, nr;

    always @(posedge clk) begin
        if (bus.step_valid === 1'b1) sv_count <= sv_count + 1;
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_pos(input string tag);
        check({tag, "_l"}, int'(bus.pos_l), ml);
        check({tag, "_m"}, int'(bus.pos_m), mm);
        check({tag, "_r"}, int'(bus.pos_r), mr);
    endtask

    function automatic int clean(input int v);
        return (v >= ALPHA) ? 0 : v;
    endfunction

    task automatic set_notch(input int m, input int r);
        nm = m;
        nr = r;
        bus.notch_m = WIDTH'(m);
        bus.notch_r = WIDTH'(r);
    endtask

    // Entered and left #1 after a rising edge with the DUT idle.
    task automatic do_load(input string tag, input int l, input int m, input int r,
                           input bit with_key);
        bus.load       = 1'b1;
        bus.key_valid  = with_key;
        bus.load_pos_l = WIDTH'(l);
        bus.load_pos_m = WIDTH'(m);
        bus.load_pos_r = WIDTH'(r);
        @(negedge clk);
        check({tag, "_rdy"}, int'(bus.key_ready), 0);
        @(posedge clk); #1;
        bus.load      = 1'b0;
        bus.key_valid = 1'b0;
        ml = clean(l); mm = clean(m); mr = clean(r);
        @(negedge clk);
        check_pos(tag);
        check({tag, "_busy"}, int'(bus.busy), 0);
        @(posedge clk); #1;
    endtask

    // hold=1 keeps key_valid high and raises load for the whole busy window.
    task automatic do_key(input string tag, input bit hold);
        bit sm, sl;
        int hl, hm, hr;
        hl = $urandom_range(0, 31); hm = $urandom_range(0, 31); hr = $urandom_range(0, 31);
`ifdef DOUBLE_STEP_EN
        sm = (mr == nr) || (mm == nm);
        sl = (mm == nm);
`else
        sm = (mr == nr);
        sl = sm && (mm == nm);
`endif
        bus.key_valid = 1'b1;
        @(negedge clk);
        check({tag, "_rdy"}, int'(bus.key_ready), 1);
        @(posedge clk); #1;
        if (hold) begin
            bus.load       = 1'b1;
            bus.load_pos_l = WIDTH'(hl);
            bus.load_pos_m = WIDTH'(hm);
            bus.load_pos_r = WIDTH'(hr);
        end else begin
            bus.key_valid = 1'b0;
        end
        @(negedge clk);
        check({tag, "_busy1"}, int'(bus.busy), 1);
        check({tag, "_rdy1"}, int'(bus.key_ready), 0);
        @(posedge clk); @(negedge clk);
        check_pos({tag, "_pre"});
        check({tag, "_sv2"}, int'(bus.step_valid), 0);
        @(posedge clk); @(negedge clk);
        mr = (mr + 1) % ALPHA;
        if (sm) mm = (mm + 1) % ALPHA;
        if (sl) ml = (ml + 1) % ALPHA;
        exp_pulses++;
        check({tag, "_sv3"}, int'(bus.step_valid), 1);
        check_pos(tag);
        @(posedge clk); @(negedge clk);
        check({tag, "_sv4"}, int'(bus.step_valid), 0);
        check({tag, "_busy4"}, int'(bus.busy), 0);
        check({tag, "_rdy4"}, int'(bus.key_ready), hold ? 0 : 1);
        @(posedge clk); #1;
        if (hold) begin
            bus.load      = 1'b0;
            bus.key_valid = 1'b0;
            ml = clean(hl); mm = clean(hm); mr = clean(hr);
            @(negedge clk);
            check_pos({tag, "_ld"});
            check({tag, "_busy5"}, int'(bus.busy), 0);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        n_tests = 0; n_fail = 0; sv_count = 0; exp_pulses = 0;
        ml = 0; mm = 0; mr = 0;
        rst = 1'b1;
        bus.load = 1'b0; bus.key_valid = 1'b0;
        bus.load_pos_l = '0; bus.load_pos_m = '0; bus.load_pos_r = '0;
        set_notch(4, 16);
        repeat (2) @(posedge clk);
        #1;
        check_pos("rst");
        check("rst_busy", int'(bus.busy), 0);
        check("rst_sv", int'(bus.step_valid), 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("rst_rdy", int'(bus.key_ready), 1);

        // first key from zero: only the right rotor moves
        do_key("k0", 1'b0);
        check("k0_const", int'(bus.pos_r), 1);

        // wrap plus carry
        set_notch(4, 25);
        do_load("ld25", 0, 0, 25, 1'b0);
        do_key("wrap", 1'b0);
        check("wrap_m", int'(bus.pos_m), 1);
        check("wrap_r", int'(bus.pos_r), 0);

        // double-stepping sequence
        set_notch(4, 16);
        do_load("ld316", 0, 3, 16, 1'b0);
        do_key("ds1", 1'b0);
        check("ds1_m", int'(bus.pos_m), 4);
        check("ds1_r", int'(bus.pos_r), 17);
        do_key("ds2", 1'b0);
`ifdef DOUBLE_STEP_EN
        check("ds2_l", int'(bus.pos_l), 1);
        check("ds2_m", int'(bus.pos_m), 5);
`else
        check("ds2_l", int'(bus.pos_l), 0);
        check("ds2_m", int'(bus.pos_m), 4);
`endif
        check("ds2_r", int'(bus.pos_r), 18);

        // load and key together: load wins, out-of-range values clear
        do_load("ldkey", 30, 2, 27, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        check("ldkey_pulses", sv_count, exp_pulses);

        // reset during STEP abandons the step
        do_load("ldrst", 5, 6, 7, 1'b0);
        bus.key_valid = 1'b1;
        @(posedge clk); #1;
        bus.key_valid = 1'b0;
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        ml = 0; mm = 0; mr = 0;
        check_pos("arst");
        check("arst_busy", int'(bus.busy), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("arst_pulses", sv_count, exp_pulses);

        // key and load held through the busy window
        do_key("hold", 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check("hold_pulses", sv_count, exp_pulses);

        // randomized traffic
        for (int i = 0; i < 150; i++) begin
            int rm, rn;
            rm = ($urandom_range(0, 3) == 0) ? mm : int'($urandom_range(0, 31));
            rn = ($urandom_range(0, 2) == 0) ? mr : int'($urandom_range(0, 31));
            set_notch(rm, rn);
            if ($urandom_range(0, 4) == 0)
                do_load("rld", int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                        int'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
            else
                do_key("rkey", 1'($urandom_range(0, 9) == 0));
        end
        check("final_pulses", sv_count, exp_pulses);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
